// File: rtl/lcd_mux_driver.sv
// lcd_mux_driver: 1/4-duty, 1/3-bias multiplexed LCD driver (4 COM, 8 SEG) with PWM-encoded 4-level outputs
module lcd_mux_driver #(
    parameter longint CLOCK_HZ      = 10_000_000,
    parameter longint CHANGE_COM_US = 1000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Digit3_i,
    input  logic [7:0] Digit2_i,
    input  logic [7:0] Digit1_i,
    input  logic [7:0] Digit0_i,
    output logic [3:0] ComPWM_o,
    output logic [7:0] SegPWM_o
);
    localparam longint RAW_TICKS   = CLOCK_HZ * CHANGE_COM_US / 1_000_000;
    localparam int     STATE_TICKS = (RAW_TICKS < 1) ? 1 : int'(RAW_TICKS);
    localparam int     DIV_W       = (STATE_TICKS > 1) ? $clog2(STATE_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STATE_TICKS - 1);

    logic [DIV_W-1:0] divider;
    logic             change_state;
    logic [2:0]       state;
    logic [1:0]       active_com;
    logic             polarity;
    logic [1:0]       pwm_cnt;
    logic [7:0]       digits [0:3];
    logic [7:0]       seg_on;
    logic [1:0]       com_analog [0:3];
    logic [1:0]       seg_analog [0:7];

    assign digits[0]    = Digit0_i;
    assign digits[1]    = Digit1_i;
    assign digits[2]    = Digit2_i;
    assign digits[3]    = Digit3_i;
    assign active_com   = state[2:1];
    assign polarity     = state[0];
    assign change_state = !Reset && (divider == DIV_LAST);

    // pick, for each SEG line, the digit bit belonging to the currently driven COM
    always_comb begin
        seg_on = '0;
        for (int s = 0; s < 8; s++)
            seg_on[s] = digits[s / 2][(s % 2) * 4 + int'(active_com)];
    end

    // timebase: divider wraps every STATE_TICKS cycles and advances the drive state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            divider <= '0;
            state   <= '0;
        end else if (change_state) begin
            divider <= '0;
            state   <= state + 3'd1;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    // analog levels: selected COM at the rail, others at 1/3 or 2/3; SEG on opposite rail when lit
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int c = 0; c < 4; c++) com_analog[c] <= '0;
            for (int s = 0; s < 8; s++) seg_analog[s] <= '0;
        end else begin
            for (int c = 0; c < 4; c++)
                com_analog[c] <= (c == int'(active_com)) ? (polarity ? 2'd0 : 2'd3)
                                                          : (polarity ? 2'd2 : 2'd1);
            for (int s = 0; s < 8; s++)
                seg_analog[s] <= polarity ? (seg_on[s] ? 2'd3 : 2'd1)
                                          : (seg_on[s] ? 2'd0 : 2'd2);
        end
    end

    // 3-phase PWM: each line is high for 'level' of every three clocks
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pwm_cnt  <= '0;
            ComPWM_o <= '0;
            SegPWM_o <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == 2'd2) ? 2'd0 : pwm_cnt + 2'd1;
            for (int c = 0; c < 4; c++) ComPWM_o[c] <= pwm_cnt < com_analog[c];
            for (int s = 0; s < 8; s++) SegPWM_o[s] <= pwm_cnt < seg_analog[s];
        end
    end
endmodule

// File: tb/tb_lcd_mux_driver.sv
// tb_lcd_mux_driver: directed-vector bench for lcd_mux_driver with a 50-clock drive state
module tb_lcd_mux_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d3 = '0, d2 = '0, d1 = '0, d0 = '0;
    logic [3:0] com_pwm;
    logic [7:0] seg_pwm;
    int         n_vec = 0, n_bad = 0;
    int         edge_n = 0, pulses = 0;
    logic [7:0]  com_pk;
    logic [15:0] seg_pk;
    logic [7:0]  com_tab [8] = '{8'h57, 8'hA8, 8'h5D, 8'hA2, 8'h75, 8'h8A, 8'hD5, 8'h2A};
    logic [15:0] seg_tab [8] = '{16'hAA2A, 16'h55D5, 16'hAAAA, 16'h5555,
                                 16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};

    lcd_mux_driver #(.CLOCK_HZ(1_000_000), .CHANGE_COM_US(50)) dut (
        .Clock(clk), .Reset(rst),
        .Digit3_i(d3), .Digit2_i(d2), .Digit1_i(d1), .Digit0_i(d0),
        .ComPWM_o(com_pwm), .SegPWM_o(seg_pwm)
    );

    always #5 clk = ~clk;

    assign com_pk = {dut.com_analog[3], dut.com_analog[2], dut.com_analog[1], dut.com_analog[0]};
    assign seg_pk = {dut.seg_analog[7], dut.seg_analog[6], dut.seg_analog[5], dut.seg_analog[4],
                     dut.seg_analog[3], dut.seg_analog[2], dut.seg_analog[1], dut.seg_analog[0]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        edge_n++;
        if (dut.change_state) pulses++;
    endtask

    task automatic go_to(input int target);
        while (edge_n < target) step();
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p;
        repeat (3) step();
        chk("rst_com", com_pwm, 4'h0);
        chk("rst_seg", seg_pwm, 8'h00);
        chk("rst_state", dut.state, 3'd0);
        chk("rst_change", dut.change_state, 1'b0);
        d1 = 8'h10;
        rst = 1'b0;
        edge_n = 0;
        pulses = 0;
        step();
        chk("s0_state", dut.state, 3'd0);
        chk("s0_com", com_pk, com_tab[0]);
        chk("s0_seg", seg_pk, seg_tab[0]);
        chk("lag_com", com_pwm, 4'h0);
        chk("lag_seg", seg_pwm, 8'h00);
        for (int k = 2; k <= 7; k++) begin
            step();
            p = (k - 1) % 3;
            chk($sformatf("pwm_com_e%0d", k), com_pwm, (p < 1) ? 4'hF : 4'h1);
            chk($sformatf("pwm_seg_e%0d", k), seg_pwm, (p < 2) ? 8'hF7 : 8'h00);
        end
        go_to(48);
        chk("e48_change", dut.change_state, 1'b0);
        go_to(49);
        chk("e49_change", dut.change_state, 1'b1);
        chk("e49_state", dut.state, 3'd0);
        go_to(50);
        chk("e50_state", dut.state, 3'd1);
        chk("e50_change", dut.change_state, 1'b0);
        for (int s = 1; s < 8; s++) begin
            go_to(50 * s + 1);
            chk($sformatf("state_s%0d", s), dut.state, 32'(s));
            chk($sformatf("com_s%0d", s), com_pk, com_tab[s]);
            chk($sformatf("seg_s%0d", s), seg_pk, seg_tab[s]);
        end
        go_to(400);
        chk("wrap_state", dut.state, 3'd0);
        chk("wrap_pulses", pulses, 8);
        go_to(401);
        chk("pre_dig_seg", seg_pk, 16'hAA2A);
        d0 = 8'h01;
        step();
        chk("dig_seg", seg_pk, 16'hAA28);
        go_to(660);
        chk("mid_state", dut.state, 3'd5);
        rst = 1'b1;
        step();
        chk("mid_rst_com", com_pwm, 4'h0);
        chk("mid_rst_seg", seg_pwm, 8'h00);
        chk("mid_rst_state", dut.state, 3'd0);
        chk("mid_rst_analog", com_pk, 8'h00);
        rst = 1'b0;
        edge_n = 0;
        step();
        chk("re_com", com_pk, 8'h57);
        go_to(48);
        chk("re_e48_change", dut.change_state, 1'b0);
        go_to(49);
        chk("re_e49_change", dut.change_state, 1'b1);
        go_to(50);
        chk("re_e50_state", dut.state, 3'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
